pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline.
- Drives PC write enable, the IF/ID write enable, and the IF/ID and ID/EX flushes.
- Detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and sequences the multi-cycle mult/div unit.
- Sits beside the ID stage and takes register indices from ID and control from EX.

---
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, redirect squash, mult/div sequencing.
// Optional saturating stall/flush counters are compiled in with HAZ_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_redirect,
    input  logic       id_md_start,
    input  logic       id_md_use,
    output logic       pc_wr,
    output logic       if_id_wr,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] md_stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MD_LAT - 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             lu, mdh, accept;

    // A load into $0 never produces a value anyone waits for.
    always_comb begin
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    end

    assign md_busy = (state == MD_RUN);
    assign md_done = (state == MD_DONE);
    assign mdh     = md_busy && (id_md_start || id_md_use);
    assign accept  = id_md_start && !ex_redirect && !lu && !mdh;

    always_comb begin
        pc_wr       = 1'b1;
        if_id_wr    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst) begin
            if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu || mdh) begin
                pc_wr       = 1'b0;
                if_id_wr    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // A redirect never aborts a running op: it was issued on the correct path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        state <= MD_RUN;
                        cnt   <= RELOAD;
                    end
                end
                MD_RUN: begin
                    if (cnt == '0) state <= MD_DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                MD_DONE: begin
                    if (accept) begin
                        state <= MD_RUN;
                        cnt   <= RELOAD;
                    end else begin
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_stall_cnt <= '0;
            md_stall_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (!ex_redirect && lu)         lu_stall_cnt <= sat_inc(lu_stall_cnt);
            if (!ex_redirect && !lu && mdh) md_stall_cnt <= sat_inc(md_stall_cnt);
            if (ex_redirect)                flush_cnt    <= sat_inc(flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: combinational vector table plus mult/div sequences.
// A second instance with MD_LAT = 1 covers the single-cycle latency boundary.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       redirect;
        logic       md_start;
        logic       md_use;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [5:0] exp;   // {pc_wr, if_id_wr, if_id_flush, id_ex_flush, md_busy, md_done}
    } vec_t;

    logic       clk, rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_redirect, id_md_start, id_md_use;
    logic       pc_wr, if_id_wr, if_id_flush, id_ex_flush, md_busy, md_done;
    logic       pc_wr1, if_id_wr1, if_id_flush1, id_ex_flush1, md_busy1, md_done1;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];

    localparam logic [5:0] RUN_OK = 6'b110000;
    localparam logic [5:0] STALL  = 6'b000100;
    localparam logic [5:0] FLUSH  = 6'b111100;
    localparam logic [5:0] BUSY   = 6'b110010;
    localparam logic [5:0] MDSTL  = 6'b000110;
    localparam logic [5:0] DONE   = 6'b110001;

    pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .id_md_start(id_md_start), .id_md_use(id_md_use),
        .pc_wr(pc_wr), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .md_busy(md_busy), .md_done(md_done)
    );

    pipe_hazard_ctrl #(.MD_LAT(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .id_md_start(id_md_start), .id_md_use(id_md_use),
        .pc_wr(pc_wr1), .if_id_wr(if_id_wr1), .if_id_flush(if_id_flush1),
        .id_ex_flush(id_ex_flush1), .md_busy(md_busy1), .md_done(md_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {pc_wr, if_id_wr, if_id_flush, id_ex_flush, md_busy, md_done};
    endfunction

    task automatic chk(input string n, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", n, got, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_uses_rs  = v.uses_rs;
        id_uses_rt  = v.uses_rt;
        ex_mem_read = v.mem_read;
        ex_rt       = v.ex_rt;
        ex_redirect = v.redirect;
        id_md_start = v.md_start;
        id_md_use   = v.md_use;
    endtask

    // One cycle: drive after the edge, expect queued, compare on the falling edge.
    task automatic step(input string n, input in_t v, input logic [5:0] e);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(e);
        @(negedge clk);
        chk(n, outs(), exp_q.pop_front());
    endtask

    function automatic in_t mk(input logic md_start, input logic md_use, input logic redirect);
        in_t v;
        v = '0;
        v.md_start = md_start;
        v.md_use   = md_use;
        v.redirect = redirect;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        in_t lu_in;
        lu_in = '0;
        lu_in.mem_read = 1'b1; lu_in.ex_rt = 5'd8; lu_in.uses_rs = 1'b1; lu_in.rs = 5'd8;

        vecs[0] = '{"idle",          '0, RUN_OK};
        vecs[1] = '{"lu_rs",         lu_in, STALL};
        vecs[2] = '{"lu_rt",         '{rs:5'd3, rt:5'd8, uses_rs:1'b1, uses_rt:1'b1, mem_read:1'b1,
                                       ex_rt:5'd8, redirect:1'b0, md_start:1'b0, md_use:1'b0}, STALL};
        vecs[3] = '{"lu_r0",         '{rs:5'd0, rt:5'd0, uses_rs:1'b1, uses_rt:1'b1, mem_read:1'b1,
                                       ex_rt:5'd0, redirect:1'b0, md_start:1'b0, md_use:1'b0}, RUN_OK};
        vecs[4] = '{"rt_unused",     '{rs:5'd1, rt:5'd8, uses_rs:1'b1, uses_rt:1'b0, mem_read:1'b1,
                                       ex_rt:5'd8, redirect:1'b0, md_start:1'b0, md_use:1'b0}, RUN_OK};
        vecs[5] = '{"not_load",      '{rs:5'd8, rt:5'd0, uses_rs:1'b1, uses_rt:1'b0, mem_read:1'b0,
                                       ex_rt:5'd8, redirect:1'b0, md_start:1'b0, md_use:1'b0}, RUN_OK};
        vecs[6] = '{"redirect_lu",   '{rs:5'd8, rt:5'd0, uses_rs:1'b1, uses_rt:1'b0, mem_read:1'b1,
                                       ex_rt:5'd8, redirect:1'b1, md_start:1'b0, md_use:1'b0}, FLUSH};
        vecs[7] = '{"redirect",      mk(1'b0, 1'b0, 1'b1), FLUSH};
        vecs[8] = '{"rs_mismatch",   '{rs:5'd9, rt:5'd7, uses_rs:1'b1, uses_rt:1'b1, mem_read:1'b1,
                                       ex_rt:5'd8, redirect:1'b0, md_start:1'b0, md_use:1'b0}, RUN_OK};
        vecs[9] = '{"md_use_idle",   mk(1'b0, 1'b1, 1'b0), RUN_OK};

        // Reset forces defaults even with a load-use pattern on the inputs.
        rst = 1'b1;
        drive(lu_in);
        #3;
        chk("reset_outs", outs(), RUN_OK);
        chk("reset_md1", {md_busy1, md_done1}, 2'b00);
        drive('0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(vecs[i].name, vecs[i].in, vecs[i].exp);

        // Load-use resolves the next cycle.
        step("lu_once", lu_in, STALL);
        step("lu_release", '0, RUN_OK);

        // Single op with a dependent mfhi stalling until MD_DONE.
        step("md_accept", mk(1'b1, 1'b0, 1'b0), RUN_OK);
        chk("md1_idle", {md_busy1, md_done1}, 2'b00);
        step("md_T", '0, BUSY);
        chk("md1_busy", {md_busy1, md_done1}, 2'b10);
        step("md_use_T1", mk(1'b0, 1'b1, 1'b0), MDSTL);
        chk("md1_done", {md_busy1, md_done1}, 2'b01);
        step("md_use_T2", mk(1'b0, 1'b1, 1'b0), MDSTL);
        chk("md1_back_idle", {md_busy1, md_done1}, 2'b00);
        step("md_use_T3", mk(1'b0, 1'b1, 1'b0), MDSTL);
        step("md_use_T4", mk(1'b0, 1'b1, 1'b0), DONE);
        step("md_after", '0, RUN_OK);

        // Back-to-back ops, with a redirect that must not abort the second.
        step("b2b_accept", mk(1'b1, 1'b0, 1'b0), RUN_OK);
        step("b2b_hold_T", mk(1'b1, 1'b0, 1'b0), MDSTL);
        step("b2b_hold_T1", mk(1'b1, 1'b0, 1'b0), MDSTL);
        step("b2b_hold_T2", mk(1'b1, 1'b0, 1'b0), MDSTL);
        step("b2b_hold_T3", mk(1'b1, 1'b0, 1'b0), MDSTL);
        step("b2b_done_acc", mk(1'b1, 1'b0, 1'b0), DONE);
        step("b2b_run0", '0, BUSY);
        step("b2b_redirect", mk(1'b0, 1'b0, 1'b1), 6'b111110);
        step("b2b_run2", '0, BUSY);
        step("b2b_run3", '0, BUSY);
        step("b2b_done", '0, DONE);
        step("b2b_idle", '0, RUN_OK);
        step("idle_pad", '0, RUN_OK);

        // Reset in the middle of an op aborts without a done pulse.
        step("rst_accept", mk(1'b1, 1'b0, 1'b0), RUN_OK);
        step("rst_T", '0, BUSY);
        step("rst_T1", '0, BUSY);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", outs(), RUN_OK);
        step("rst_held", '0, RUN_OK);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step("post_rst_idle", '0, RUN_OK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
